uart_rx_fsm: RTL and testbench
==============================

# uart_rx_fsm

Frame sequencer for the UART receiver. It detects the start-bit falling edge and gates the oversampling edge/bit counter. It issues one-cycle strobes to the data sampler, deserializer and start/parity/stop checkers at fixed edge positions. At the end of a frame it qualifies the result into a single-cycle `data_valid` or `frame_err` pulse, and it sits between the RX pin sync stage and the rest of the Rx datapath.

## Interface
- `PRESCALE`, default 5'd8: oversampling ratio. Legal values are 8, 16 or 32, and it must match the counter's `PRESCALE`.
- `CLK`  in  1  receiver oversampling clock.
- `RST`  in  1  asynchronous, active-low reset.
- `RX_IN`  in  1  synchronized serial line, idle high.
- `PAR_EN`  in  1  parity bit present. Quasi-static: changed only while the FSM is in IDLE.
- `edge_cnt`  in  5  edge counter value, 0..PRESCALE-1.
- `bit_cnt`  in  4  bit index. 0 = start, 1..8 = data, 9 = parity or stop, 10 = stop (parity frames only).
- `strt_glitch`  in  1  start checker result, registered, valid from CHK+1.
- `par_err`  in  1  parity checker result, registered, valid from CHK+1.
- `stp_err`  in  1  stop checker result, registered, valid from CHK+1.
- `cnt_enable`  out  1  runs the edge/bit counter. When low, the counter clears.
- `dat_samp_en`  out  1  enables the 3-sample majority sampler.
- `deser_en`  out  1  shift strobe for one data bit.
- `strt_chk_en`  out  1  start check strobe.
- `par_chk_en`  out  1  parity check strobe.
- `stp_chk_en`  out  1  stop check strobe.
- `data_valid`  out  1  one-cycle pulse: the frame was received with no error.
- `frame_err`  out  1  one-cycle pulse: parity or stop error in a completed frame.

## Operation
- Derived constants:
  - CHK = PRESCALE/2+2, the cycle after the last majority sample at PRESCALE/2+1.
  - LAST = PRESCALE-1.
- States: IDLE, START, DATA, PARITY, STOP, VALID. The state register is clocked and resets to IDLE.
- Transitions:
  - IDLE → START when RX_IN==0.
  - START at edge LAST → IDLE if `strt_glitch`, else → DATA.
  - DATA at edge LAST with bit_cnt==8 → PARITY if PAR_EN, else → STOP.
  - PARITY at edge LAST → STOP. `par_err` is latched into internal `perr_q` at this point.
  - STOP at edge LAST → VALID. `stp_err` is latched into internal `serr_q`.
  - VALID → START if RX_IN==0 (back-to-back frame), else → IDLE. `perr_q` and `serr_q` are cleared on leaving VALID.
- Outputs are decoded combinationally from registered state, counter inputs and latched flags only:
  - `cnt_enable` is 1 in START, DATA, PARITY and STOP. It is 0 in IDLE and VALID, so the counter is cleared before every frame.
  - `dat_samp_en` = `cnt_enable`.
  - `strt_chk_en` = START && edge_cnt==CHK.
  - `deser_en` = DATA && edge_cnt==CHK.
  - `par_chk_en` = PARITY && edge_cnt==CHK.
  - `stp_chk_en` = STOP && edge_cnt==CHK.
  - `data_valid` = VALID && !perr_q && !serr_q.
  - `frame_err` = VALID && (perr_q || serr_q).
- All outputs and latched flags are 0 during reset and in IDLE.
- Reset asserted mid-frame forces IDLE immediately. The counter is cleared by its own reset and by `cnt_enable`=0.
- A start glitch aborts the frame silently: no `data_valid`, no `frame_err`. If RX_IN is still low in IDLE, a new frame begins next cycle.
- Behaviour is undefined if PAR_EN changes outside IDLE.

## Timing
- Cycle 0 is the first cycle RX_IN==0 is seen in IDLE.
- START is entered at cycle 1, with edge_cnt=0.
- The last edge of bit n is at cycle (n+1)·PRESCALE.
- `data_valid` or `frame_err` is asserted at cycle 10·PRESCALE+1 without parity, or 11·PRESCALE+1 with parity. For PRESCALE=8 these are cycles 81 and 89.
- `deser_en` pulses exactly 8 times per frame, at cycles k·PRESCALE+CHK+1 for k=1..8. The LSB arrives first, so the deserializer shifts right.
- Each check strobe pulses exactly once per bit it covers.
- Error inputs are read only at edge LAST. Their values at other cycles are ignored.
- A back-to-back frame starting in VALID has the same cycle-1 alignment as one starting from IDLE.

## Test plan
- **Clean frame:** PRESCALE=8, PAR_EN=0, byte 0xA5, checkers quiet → 8 `deser_en` pulses at cycles 15, 23, …, 71; `stp_chk_en` at cycle 79; `data_valid`=1 at cycle 81 only; `frame_err` never asserted.
- **Parity frame with error:** PAR_EN=1, `par_err`=1 from cycle 78 → `par_chk_en` at cycle 79, `stp_chk_en` at cycle 87; `frame_err`=1 at cycle 89; `data_valid` stays 0.
- **Start glitch:** RX_IN low for 2 cycles, `strt_glitch`=1 at cycle 7 → state returns to IDLE at cycle 9; no `deser_en`; both pulses stay 0.
- **Back-to-back frames:** RX_IN=0 during VALID (cycle 81) → `cnt_enable` low for exactly 1 cycle; second frame's `data_valid` at cycle 162.
- **Stop error:** `stp_err`=1 at cycle 80 → `frame_err` at cycle 81; a following clean frame gives `data_valid`, proving `serr_q` was cleared.
- **Mid-frame reset:** assert `RST` during DATA at cycle 40 → all outputs 0 immediately; after release with RX idle high, the FSM stays in IDLE and `cnt_enable`=0.

Source files
------------

// File: rtl/uart_rx_fsm.sv
// Frame sequencer for the UART receiver: tracks start/data/parity/stop bits against the
// oversampling edge counter and issues check strobes plus a one-cycle frame verdict.
module uart_rx_fsm #(
   parameter int unsigned PRESCALE = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RX_IN,
   input  logic       PAR_EN,
   input  logic [4:0] edge_cnt,
   input  logic [3:0] bit_cnt,
   input  logic       strt_glitch,
   input  logic       par_err,
   input  logic       stp_err,
   output logic       cnt_enable,
   output logic       dat_samp_en,
   output logic       deser_en,
   output logic       strt_chk_en,
   output logic       par_chk_en,
   output logic       stp_chk_en,
   output logic       data_valid,
   output logic       frame_err
);

   // CHK is the cycle after the last of the three majority samples taken around mid-bit.
   localparam logic [4:0] CHK  = 5'(PRESCALE / 2 + 2);
   localparam logic [4:0] LAST = 5'(PRESCALE - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      VALID
   } state_t;

   state_t state;
   logic   perr_q;
   logic   serr_q;
   logic   at_last;
   logic   at_chk;

   assign at_last = (edge_cnt == LAST);
   assign at_chk  = (edge_cnt == CHK);

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state  <= IDLE;
         perr_q <= 1'b0;
         serr_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!RX_IN) state <= START;
            end
            START: begin
               if (at_last) state <= strt_glitch ? IDLE : DATA;
            end
            DATA: begin
               if (at_last && (bit_cnt == 4'd8)) state <= PAR_EN ? PARITY : STOP;
            end
            PARITY: begin
               if (at_last) begin
                  state  <= STOP;
                  perr_q <= par_err;
               end
            end
            STOP: begin
               if (at_last) begin
                  state  <= VALID;
                  serr_q <= stp_err;
               end
            end
            VALID: begin
               // A low line here is the next start bit; re-enter START with the counter cleared.
               state  <= RX_IN ? IDLE : START;
               perr_q <= 1'b0;
               serr_q <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Strobes are decoded from registered state so they line up with the counter value
   // of the same cycle; a registered copy would land one edge late.
   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      cnt_enable  = 1'b0;
      strt_chk_en = 1'b0;
      deser_en    = 1'b0;
      par_chk_en  = 1'b0;
      stp_chk_en  = 1'b0;
      data_valid  = 1'b0;
      frame_err   = 1'b0;
      case (state)
         START: begin
            cnt_enable  = 1'b1;
            strt_chk_en = at_chk;
         end
         DATA: begin
            cnt_enable = 1'b1;
            deser_en   = at_chk;
         end
         PARITY: begin
            cnt_enable = 1'b1;
            par_chk_en = at_chk;
         end
         STOP: begin
            cnt_enable = 1'b1;
            stp_chk_en = at_chk;
         end
         VALID: begin
            data_valid = !perr_q && !serr_q;
            frame_err  = perr_q || serr_q;
         end
         default: begin
            cnt_enable = 1'b0;
         end
      endcase
   end

   assign dat_samp_en = cnt_enable;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: a behavioural edge/bit counter drives the DUT, and
// per-frame strobe timing is compared against hand-computed cycle numbers (PRESCALE=8).
module tb_uart_rx_fsm;

   localparam int         P    = 8;
   localparam logic [4:0] LAST = 5'(P - 1);

   // Output vector bit positions.
   localparam int O_CNT  = 7;
   localparam int O_SAMP = 6;
   localparam int O_DES  = 5;
   localparam int O_STRT = 4;
   localparam int O_PAR  = 3;
   localparam int O_STP  = 2;
   localparam int O_DV   = 1;
   localparam int O_FE   = 0;

   logic       CLK = 1'b0;
   logic       RST;
   logic       RX_IN;
   logic       PAR_EN;
   logic [4:0] edge_cnt;
   logic [3:0] bit_cnt;
   logic       strt_glitch;
   logic       par_err;
   logic       stp_err;
   logic       cnt_enable;
   logic       dat_samp_en;
   logic       deser_en;
   logic       strt_chk_en;
   logic       par_chk_en;
   logic       stp_chk_en;
   logic       data_valid;
   logic       frame_err;

   int total = 0;
   int bad   = 0;

   uart_rx_fsm #(.PRESCALE(P)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_IN      (RX_IN),
      .PAR_EN     (PAR_EN),
      .edge_cnt   (edge_cnt),
      .bit_cnt    (bit_cnt),
      .strt_glitch(strt_glitch),
      .par_err    (par_err),
      .stp_err    (stp_err),
      .cnt_enable (cnt_enable),
      .dat_samp_en(dat_samp_en),
      .deser_en   (deser_en),
      .strt_chk_en(strt_chk_en),
      .par_chk_en (par_chk_en),
      .stp_chk_en (stp_chk_en),
      .data_valid (data_valid),
      .frame_err  (frame_err)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1);
   end

   typedef struct {
      bit par_en;
      int rx_low;
      int g_from, g_to;
      int p_from, p_to;
      int s_from, s_to;
      int run_len;
      int n_deser, first_deser, last_deser;
      int strt_cyc, par_cyc, stp_cyc;
      int n_cnt;
      int dv_cyc, fe_cyc;
   } vec_t;

   task automatic check(input string name, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Samples outputs mid-cycle, then advances the counter model across the next edge.
   task automatic step(output logic [7:0] o);
      @(negedge CLK);
      o = {cnt_enable, dat_samp_en, deser_en, strt_chk_en,
           par_chk_en, stp_chk_en, data_valid, frame_err};
      @(posedge CLK);
      #1;
      if (o[O_CNT]) begin
         if (edge_cnt == LAST) begin
            edge_cnt = 5'd0;
            bit_cnt  = bit_cnt + 4'd1;
         end else begin
            edge_cnt = edge_cnt + 5'd1;
         end
      end else begin
         edge_cnt = 5'd0;
         bit_cnt  = 4'd0;
      end
   endtask

   task automatic run_vec(input int id, input vec_t v);
      logic [7:0] o;
      int n_des = 0, f_des = -1, l_des = -1;
      int n_strt = 0, c_strt = -1, n_par = 0, c_par = -1, n_stp = 0, c_stp = -1;
      int n_dv = 0, c_dv = -1, n_fe = 0, c_fe = -1, n_cnt = 0, n_samp = 0;
      PAR_EN = v.par_en;
      for (int c = 0; c <= v.run_len; c++) begin
         RX_IN       = (c < v.rx_low) ? 1'b0 : 1'b1;
         strt_glitch = (c >= v.g_from) && (c <= v.g_to);
         par_err     = (c >= v.p_from) && (c <= v.p_to);
         stp_err     = (c >= v.s_from) && (c <= v.s_to);
         step(o);
         if (o[O_CNT])  n_cnt++;
         if (o[O_SAMP]) n_samp++;
         if (o[O_DES]) begin
            n_des++;
            if (f_des < 0) f_des = c;
            l_des = c;
         end
         if (o[O_STRT]) begin n_strt++; c_strt = c; end
         if (o[O_PAR])  begin n_par++;  c_par  = c; end
         if (o[O_STP])  begin n_stp++;  c_stp  = c; end
         if (o[O_DV])   begin n_dv++;   c_dv   = c; end
         if (o[O_FE])   begin n_fe++;   c_fe   = c; end
      end
      RX_IN = 1'b1; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
      check($sformatf("v%0d deser_count", id), n_des, v.n_deser);
      check($sformatf("v%0d deser_first", id), f_des, v.first_deser);
      check($sformatf("v%0d deser_last", id), l_des, v.last_deser);
      check($sformatf("v%0d strt_chk_count", id), n_strt, (v.strt_cyc >= 0) ? 1 : 0);
      check($sformatf("v%0d strt_chk_cycle", id), c_strt, v.strt_cyc);
      check($sformatf("v%0d par_chk_count", id), n_par, (v.par_cyc >= 0) ? 1 : 0);
      check($sformatf("v%0d par_chk_cycle", id), c_par, v.par_cyc);
      check($sformatf("v%0d stp_chk_count", id), n_stp, (v.stp_cyc >= 0) ? 1 : 0);
      check($sformatf("v%0d stp_chk_cycle", id), c_stp, v.stp_cyc);
      check($sformatf("v%0d cnt_enable_cycles", id), n_cnt, v.n_cnt);
      check($sformatf("v%0d dat_samp_cycles", id), n_samp, v.n_cnt);
      check($sformatf("v%0d data_valid_count", id), n_dv, (v.dv_cyc >= 0) ? 1 : 0);
      check($sformatf("v%0d data_valid_cycle", id), c_dv, v.dv_cyc);
      check($sformatf("v%0d frame_err_count", id), n_fe, (v.fe_cyc >= 0) ? 1 : 0);
      check($sformatf("v%0d frame_err_cycle", id), c_fe, v.fe_cyc);
   endtask

   initial begin
      vec_t       vecs[11];
      logic [7:0] o;
      int         n_dv, c_dv, n_fe, c_fe, n_low, n_des, n_strt, n_busy;

      //  par rx  glitch   perr     serr    run  ndes first last strt par stp  cnt  dv  fe
      vecs[0]  = '{0, 8, -1, -1, -1, -1, -1, -1, 95, 8, 15, 71, 7, -1, 79, 80, 81, -1};
      vecs[1]  = '{0, 8, -1, -1, -1, -1, 80, 95, 95, 8, 15, 71, 7, -1, 79, 80, -1, 81};
      vecs[2]  = '{0, 8, -1, -1, -1, -1, -1, -1, 95, 8, 15, 71, 7, -1, 79, 80, 81, -1};
      vecs[3]  = '{1, 8, -1, -1, 78, 95, -1, -1, 95, 8, 15, 71, 7, 79, 87, 88, -1, 89};
      vecs[4]  = '{1, 8, -1, -1, -1, -1, -1, -1, 95, 8, 15, 71, 7, 79, 87, 88, 89, -1};
      // Errors asserted everywhere except edge LAST must be ignored.
      vecs[5]  = '{1, 8,  5,  7, 77, 79, 86, 87, 95, 8, 15, 71, 7, 79, 87, 88, 89, -1};
      vecs[6]  = '{1, 8, -1, -1, -1, -1, 88, 88, 95, 8, 15, 71, 7, 79, 87, 88, -1, 89};
      vecs[7]  = '{1, 8, -1, -1, 80, 80, 88, 88, 95, 8, 15, 71, 7, 79, 87, 88, -1, 89};
      vecs[8]  = '{0, 2,  7,  8, -1, -1, -1, -1, 20, 0, -1, -1, 7, -1, -1,  8, -1, -1};
      vecs[9]  = '{1, 2,  8,  8, -1, -1, -1, -1, 20, 0, -1, -1, 7, -1, -1,  8, -1, -1};
      vecs[10] = '{0, 8, -1, -1, -1, -1, 79, 79, 95, 8, 15, 71, 7, -1, 79, 80, 81, -1};

      // Reset state, with the line held low to show reset dominates.
      RST = 1'b0; RX_IN = 1'b0; PAR_EN = 1'b0; strt_glitch = 1'b0;
      par_err = 1'b0; stp_err = 1'b0; edge_cnt = 5'd0; bit_cnt = 4'd0;
      n_busy = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         if ({cnt_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
              stp_chk_en, data_valid, frame_err} != 8'h00) n_busy++;
      end
      check("reset_outputs_zero", n_busy, 0);
      @(posedge CLK); #1;
      RX_IN = 1'b1; RST = 1'b1;
      n_busy = 0;
      for (int i = 0; i < 4; i++) begin
         step(o);
         if (o != 8'h00) n_busy++;
      end
      check("idle_after_reset", n_busy, 0);

      for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

      // Back-to-back: first frame has a stop error, second starts in VALID and is clean.
      PAR_EN = 1'b0;
      n_dv = 0; c_dv = -1; n_fe = 0; c_fe = -1; n_low = 0; n_des = 0;
      for (int c = 0; c <= 170; c++) begin
         RX_IN   = ((c <= 7) || (c >= 81 && c <= 88)) ? 1'b0 : 1'b1;
         stp_err = (c == 80);
         step(o);
         if (c >= 1 && c <= 161 && !o[O_CNT]) n_low++;
         if (o[O_DES]) n_des++;
         if (o[O_DV]) begin n_dv++; c_dv = c; end
         if (o[O_FE]) begin n_fe++; c_fe = c; end
      end
      RX_IN = 1'b1; stp_err = 1'b0;
      check("b2b_cnt_low_cycles", n_low, 1);
      check("b2b_deser_count", n_des, 16);
      check("b2b_frame_err_count", n_fe, 1);
      check("b2b_frame_err_cycle", c_fe, 81);
      check("b2b_data_valid_count", n_dv, 1);
      check("b2b_data_valid_cycle", c_dv, 162);

      // Start glitch while the line is still low: restart from IDLE on the next cycle.
      n_dv = 0; c_dv = -1; n_fe = 0; n_low = 0; n_des = 0; n_strt = 0;
      for (int c = 0; c <= 100; c++) begin
         RX_IN       = (c <= 9) ? 1'b0 : 1'b1;
         strt_glitch = (c == 7) || (c == 8);
         step(o);
         if (c >= 1 && c <= 89 && !o[O_CNT]) n_low++;
         if (o[O_DES])  n_des++;
         if (o[O_STRT]) n_strt++;
         if (o[O_DV]) begin n_dv++; c_dv = c; end
         if (o[O_FE]) n_fe++;
      end
      RX_IN = 1'b1; strt_glitch = 1'b0;
      check("glitch_restart_cnt_low", n_low, 1);
      check("glitch_restart_strt_chk", n_strt, 2);
      check("glitch_restart_deser", n_des, 8);
      check("glitch_restart_dv_count", n_dv, 1);
      check("glitch_restart_dv_cycle", c_dv, 90);
      check("glitch_restart_fe_count", n_fe, 0);

      // Mid-frame reset during DATA at cycle 40.
      for (int c = 0; c < 40; c++) begin
         RX_IN = (c <= 7) ? 1'b0 : 1'b1;
         step(o);
      end
      RX_IN = 1'b1;
      #1;
      check("pre_reset_cnt_enable", int'(cnt_enable), 1);
      #1;
      RST = 1'b0;
      #1;
      check("mid_reset_outputs", int'({cnt_enable, dat_samp_en, deser_en, strt_chk_en,
                                       par_chk_en, stp_chk_en, data_valid, frame_err}), 0);
      edge_cnt = 5'd0; bit_cnt = 4'd0;
      @(posedge CLK); @(posedge CLK); #1;
      RST = 1'b1;
      n_busy = 0;
      for (int i = 0; i < 20; i++) begin
         step(o);
         if (o != 8'h00) n_busy++;
      end
      check("post_reset_idle", n_busy, 0);
      run_vec(11, vecs[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
